// File: rtl/guess_scorer.sv
// MasterMind scoring engine: latches a secret and a guess on START, counts exact-position
// matches peg by peg, then colour-only matches colour by colour via per-colour histograms.
//
// state      | meaning
// IDLE       | waiting for START; operands latched on the accepting edge
// EXACT_PASS | one peg per cycle: exact compare, else bump both histograms
// COLOR_PASS | one colour per cycle: add min(hist_s, hist_g) to partial
// FINISH     | publish results, pulse DONE, back to IDLE
module guess_scorer #(
  parameter int PEGS    = 4,
  parameter int COLOR_W = 3,
  parameter int CNT_W   = $clog2(PEGS + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [PEGS*COLOR_W-1:0]   SECRET,
  input  logic [PEGS*COLOR_W-1:0]   GUESS,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [CNT_W-1:0]          EXACT,
  output logic [CNT_W-1:0]          PARTIAL,
  output logic                      WIN
);

  localparam int NCOL  = 2 ** COLOR_W;
  localparam int MAXN  = (PEGS > NCOL) ? PEGS : NCOL;
  localparam int IDX_W = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXACT_PASS = 2'd1,
    COLOR_PASS = 2'd2,
    FINISH     = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [PEGS*COLOR_W-1:0]   sec_q, sec_d;
  logic [PEGS*COLOR_W-1:0]   gss_q, gss_d;
  logic [CNT_W-1:0]          hist_s_q [NCOL];
  logic [CNT_W-1:0]          hist_s_d [NCOL];
  logic [CNT_W-1:0]          hist_g_q [NCOL];
  logic [CNT_W-1:0]          hist_g_d [NCOL];
  logic [CNT_W-1:0]          exact_acc_q, exact_acc_d;
  logic [CNT_W-1:0]          part_acc_q, part_acc_d;
  logic [CNT_W-1:0]          exact_q, exact_d;
  logic [CNT_W-1:0]          partial_q, partial_d;
  logic                      win_q, win_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;

  logic [COLOR_W-1:0]        s_cur, g_cur;
  logic [CNT_W-1:0]          hs_cur, hg_cur, hmin;

  // Loop muxes keep the index width independent of PEGS/NCOL array bounds.
  always_comb begin
    s_cur  = '0;
    g_cur  = '0;
    hs_cur = '0;
    hg_cur = '0;
    for (int p = 0; p < PEGS; p++) begin
      if (idx_q == IDX_W'(p)) begin
        s_cur = sec_q[p*COLOR_W +: COLOR_W];
        g_cur = gss_q[p*COLOR_W +: COLOR_W];
      end
    end
    for (int c = 0; c < NCOL; c++) begin
      if (idx_q == IDX_W'(c)) begin
        hs_cur = hist_s_q[c];
        hg_cur = hist_g_q[c];
      end
    end
    hmin = (hs_cur < hg_cur) ? hs_cur : hg_cur;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sec_d       = sec_q;
    gss_d       = gss_q;
    hist_s_d    = hist_s_q;
    hist_g_d    = hist_g_q;
    exact_acc_d = exact_acc_q;
    part_acc_d  = part_acc_q;
    exact_d     = exact_q;
    partial_d   = partial_q;
    win_d       = win_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          sec_d       = SECRET;
          gss_d       = GUESS;
          exact_acc_d = '0;
          part_acc_d  = '0;
          idx_d       = '0;
          for (int c = 0; c < NCOL; c++) begin
            hist_s_d[c] = '0;
            hist_g_d[c] = '0;
          end
          state_d = EXACT_PASS;
        end
      end
      EXACT_PASS: begin
        if (s_cur == g_cur) begin
          exact_acc_d = exact_acc_q + CNT_W'(1);
        end else begin
          hist_s_d[s_cur] = hist_s_q[s_cur] + CNT_W'(1);
          hist_g_d[g_cur] = hist_g_q[g_cur] + CNT_W'(1);
        end
        if (idx_q == IDX_W'(PEGS - 1)) begin
          idx_d   = '0;
          state_d = COLOR_PASS;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      COLOR_PASS: begin
        part_acc_d = part_acc_q + hmin;
        if (idx_q == IDX_W'(NCOL - 1)) begin
          idx_d   = '0;
          state_d = FINISH;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FINISH: begin
        exact_d   = exact_acc_q;
        partial_d = part_acc_q;
        win_d     = (exact_acc_q == CNT_W'(PEGS));
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // BUSY stays up through the DONE cycle even though the FSM is already back in IDLE.
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sec_q       <= '0;
      gss_q       <= '0;
      exact_acc_q <= '0;
      part_acc_q  <= '0;
      exact_q     <= '0;
      partial_q   <= '0;
      win_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int c = 0; c < NCOL; c++) begin
        hist_s_q[c] <= '0;
        hist_g_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sec_q       <= sec_d;
      gss_q       <= gss_d;
      exact_acc_q <= exact_acc_d;
      part_acc_q  <= part_acc_d;
      exact_q     <= exact_d;
      partial_q   <= partial_d;
      win_q       <= win_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      hist_s_q    <= hist_s_d;
      hist_g_q    <= hist_g_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign EXACT   = exact_q;
  assign PARTIAL = partial_q;
  assign WIN     = win_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: expected scores come from a counting model and are
// queued at START, then popped and compared when DONE pulses.
module tb_guess_scorer;

  localparam int PEGS    = 4;
  localparam int COLOR_W = 3;
  localparam int CNT_W   = 3;
  localparam int LAT     = 13;

  logic                    CLK;
  logic                    RST;
  logic                    START;
  logic [PEGS*COLOR_W-1:0] SECRET;
  logic [PEGS*COLOR_W-1:0] GUESS;
  logic                    BUSY;
  logic                    DONE;
  logic [CNT_W-1:0]        EXACT;
  logic [CNT_W-1:0]        PARTIAL;
  logic                    WIN;

  guess_scorer #(.PEGS(PEGS), .COLOR_W(COLOR_W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .SECRET  (SECRET),
    .GUESS   (GUESS),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .EXACT   (EXACT),
    .PARTIAL (PARTIAL),
    .WIN     (WIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int ex;
    int pa;
    int win;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [11:0] pk(input int p0, input int p1, input int p2, input int p3);
    logic [11:0] v;
    v = {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    return v;
  endfunction

  // Score by total colour overlap minus exact hits.
  function automatic exp_t score(input logic [11:0] s, input logic [11:0] g);
    exp_t r;
    int cs[8];
    int cg[8];
    int tot;
    for (int c = 0; c < 8; c++) begin
      cs[c] = 0;
      cg[c] = 0;
    end
    r.ex = 0;
    for (int p = 0; p < PEGS; p++) begin
      if (s[p*3 +: 3] == g[p*3 +: 3]) r.ex++;
      cs[s[p*3 +: 3]]++;
      cg[g[p*3 +: 3]]++;
    end
    tot = 0;
    for (int c = 0; c < 8; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    r.pa  = tot - r.ex;
    r.win = (r.ex == PEGS) ? 1 : 0;
    return r;
  endfunction

  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_exact"}, 32'(EXACT), 32'(e.ex));
      chk({tag, "_partial"}, 32'(PARTIAL), 32'(e.pa));
      chk({tag, "_win"}, 32'(WIN), 32'(e.win));
    end
  endtask

  // Full transaction from the edge that samples START to the edge after DONE.
  task automatic run_game(input string tag, input logic [11:0] s, input logic [11:0] g);
    int n;
    bit found;
    sb.push_back(score(s, g));
    SECRET = s;
    GUESS  = g;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    SECRET = '0;
    GUESS  = '0;
    chk({tag, "_busy0"}, 32'(BUSY), 32'd1);
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (DONE) found = 1;
      else if (n < LAT) chk({tag, "_busy_mid"}, 32'(BUSY), 32'd1);
    end
    chk({tag, "_done_edge"}, 32'(n), 32'(LAT));
    chk({tag, "_busy_done"}, 32'(BUSY), 32'd1);
    pop_cmp(tag);
    tick();
    chk({tag, "_done_clr"}, 32'(DONE), 32'd0);
    chk({tag, "_busy_clr"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int hits;
    int dcnt;
    exp_t last;

    RST    = 1'b1;
    START  = 1'b0;
    SECRET = '0;
    GUESS  = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_exact", 32'(EXACT), 32'd0);
    chk("rst_partial", 32'(PARTIAL), 32'd0);
    chk("rst_win", 32'(WIN), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    hits = 0;
    repeat (100) begin
      tick();
      hits += int'(BUSY) + int'(DONE);
    end
    chk("idle_quiet", 32'(hits), 32'd0);

    run_game("win",   pk(0, 1, 2, 3), pk(0, 1, 2, 3));
    run_game("perm",  pk(1, 2, 3, 4), pk(4, 3, 2, 1));
    run_game("none",  pk(7, 7, 7, 7), pk(0, 0, 0, 0));
    run_game("dup1",  pk(1, 1, 2, 2), pk(1, 2, 1, 5));
    run_game("dup2",  pk(3, 3, 3, 3), pk(3, 0, 3, 0));

    last = score(pk(3, 3, 3, 3), pk(3, 0, 3, 0));
    repeat (5) tick();
    chk("hold_exact", 32'(EXACT), 32'(last.ex));
    chk("hold_done", 32'(DONE), 32'd0);

    // START at edges 5 and 13 must be dropped; edge 14 is the first accepted slot.
    sb.push_back(score(pk(5, 6, 7, 0), pk(5, 6, 0, 7)));
    SECRET = pk(5, 6, 7, 0);
    GUESS  = pk(5, 6, 0, 7);
    START  = 1'b1;
    tick();
    START  = 1'b0;
    dcnt   = 0;
    for (int e = 1; e <= 30; e++) begin
      if (e == 5) begin
        SECRET = pk(1, 1, 1, 1); GUESS = pk(1, 1, 1, 1); START = 1'b1;
      end else if (e == 13) begin
        SECRET = pk(4, 4, 4, 4); GUESS = pk(4, 4, 4, 4); START = 1'b1;
      end else if (e == 14) begin
        SECRET = pk(2, 4, 6, 0); GUESS = pk(0, 2, 4, 6); START = 1'b1;
        sb.push_back(score(pk(2, 4, 6, 0), pk(0, 2, 4, 6)));
      end
      tick();
      START = 1'b0;
      if (DONE) begin
        dcnt++;
        chk("bb_done_edge", 32'(e), (dcnt == 1) ? 32'd13 : 32'd27);
        pop_cmp("bb");
      end
      if (e == 14) chk("bb_busy14", 32'(BUSY), 32'd1);
    end
    chk("bb_done_count", 32'(dcnt), 32'd2);
    chk("bb_idle", 32'(BUSY), 32'd0);

    // Abort mid-evaluation; the operands leave histogram content that must not survive.
    SECRET = pk(1, 1, 2, 2);
    GUESS  = pk(2, 2, 1, 1);
    START  = 1'b1;
    tick();
    START  = 1'b0;
    repeat (7) tick();
    #2;
    RST = 1'b1;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_exact", 32'(EXACT), 32'd0);
    chk("abort_partial", 32'(PARTIAL), 32'd0);
    chk("abort_win", 32'(WIN), 32'd0);
    repeat (2) tick();
    @(negedge CLK);
    RST = 1'b0;
    hits = 0;
    repeat (20) begin
      tick();
      hits += int'(DONE) + int'(BUSY);
    end
    chk("abort_no_done", 32'(hits), 32'd0);
    run_game("post_rst", pk(0, 1, 2, 3), pk(4, 5, 6, 7));
    run_game("post_rst2", pk(1, 2, 2, 1), pk(2, 1, 1, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
